// File: rtl/kpt_pkg.sv
// Shared constants, record type, FSM encoding and word-format helpers for the
// keypoint output serializer.
package kpt_pkg;

    localparam int KPT_COLS = 640;
    localparam int KPT_ROWS = 480;
    localparam int COL_W    = 10;
    localparam int ROW_W    = 9;
    localparam int KPT_W    = 1 + COL_W + ROW_W;
    localparam int WORD_W   = 16;

    localparam logic [WORD_W-1:0] KPT_EOF_WORD = 16'hFFFF;

    // W0 = {0, layer, 0000, col}; W1 = {0000000, row}. Bit 15 is always 0,
    // so neither data word can alias the end-of-frame marker.
    localparam int W0_LAYER_BIT = 14;
    localparam int W0_COL_LSB   = 0;
    localparam int W1_ROW_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROW  = 2'd1,
        ST_CNT  = 2'd2
    } ser_state_e;

    typedef struct packed {
        logic             layer;
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
    } kpt_rec_t;

    function automatic logic [WORD_W-1:0] make_w0(input kpt_rec_t rec);
        logic [WORD_W-1:0] w;
        w                       = '0;
        w[W0_LAYER_BIT]         = rec.layer;
        w[W0_COL_LSB +: COL_W]  = rec.col;
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] make_w1(input logic [ROW_W-1:0] row);
        logic [WORD_W-1:0] w;
        w                       = '0;
        w[W1_ROW_LSB +: ROW_W]  = row;
        return w;
    endfunction

endpackage

// File: rtl/kpt_fifo.sv
// Synchronous FIFO for keypoint records: wrap-bit pointers, no pass-through,
// push ignored when full and pop ignored when empty.
module kpt_fifo
    import kpt_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = KPT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: every always_comb output gets a default before any branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // NOTE: state uses non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; emptiness is tracked by the pointers, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/kpt_out_serializer.sv
// Buffers keypoint records and serializes each into W0/W1 words, closing every
// frame with the end-of-frame marker followed by the frame's keypoint count.
module kpt_out_serializer
    import kpt_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter int          COLS       = KPT_COLS,
    parameter int          ROWS       = KPT_ROWS,
    parameter logic [15:0] EOF_WORD   = KPT_EOF_WORD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             kpt_valid,
    output logic             kpt_ready,
    input  logic [ROW_W-1:0] kpt_row,
    input  logic [COL_W-1:0] kpt_col,
    input  logic             kpt_layer,
    input  logic             frame_end,
    output logic             out_valid,
    output logic [15:0]      out_data,
    output logic [15:0]      kpt_count
);

    ser_state_e       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [15:0]      out_data_q, out_data_d;
    logic [15:0]      kpt_count_q, kpt_count_d;
    logic             eof_pending_q, eof_pending_d;
    logic [ROW_W-1:0] row_q, row_d;

    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_push;
    logic     fifo_pop;
    logic     accept;
    logic     in_range;
    kpt_rec_t wr_rec;
    kpt_rec_t rd_rec;

    // Ready is forced low while reset is held; a pending EOF holds off the next frame.
    assign kpt_ready = rst_n && !fifo_full && !eof_pending_q;
    assign accept    = kpt_valid && kpt_ready;
    assign in_range  = (int'(kpt_row) < ROWS) && (int'(kpt_col) < COLS);
    assign fifo_push = accept && in_range;
    assign wr_rec    = kpt_rec_t'{layer: kpt_layer, col: kpt_col, row: kpt_row};

    kpt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KPT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (wr_rec),
        .pop     (fifo_pop),
        .rd_data (rd_rec),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        out_valid_d   = 1'b0;
        out_data_d    = out_data_q;
        row_d         = row_q;
        fifo_pop      = 1'b0;
        kpt_count_d   = kpt_count_q;
        eof_pending_d = eof_pending_q;

        if (fifo_push && (kpt_count_q != 16'hFFFF)) kpt_count_d = kpt_count_q + 16'd1;
        if (frame_end) eof_pending_d = 1'b1;

        // Buffered records always drain before the EOF marker is considered.
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    out_valid_d = 1'b1;
                    out_data_d  = make_w0(rd_rec);
                    row_d       = rd_rec.row;
                    state_d     = ST_ROW;
                end else if (eof_pending_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = EOF_WORD;
                    state_d     = ST_CNT;
                end
            end
            ST_ROW: begin
                out_valid_d = 1'b1;
                out_data_d  = make_w1(row_q);
                state_d     = ST_IDLE;
            end
            ST_CNT: begin
                out_valid_d   = 1'b1;
                out_data_d    = kpt_count_q;
                kpt_count_d   = '0;
                eof_pending_d = 1'b0;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            kpt_count_q   <= '0;
            eof_pending_q <= 1'b0;
            row_q         <= '0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            kpt_count_q   <= kpt_count_d;
            eof_pending_q <= eof_pending_d;
            row_q         <= row_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign kpt_count = kpt_count_q;

endmodule

// File: tb/tb_kpt_out_serializer.sv
// Self-checking bench: table-driven records plus hand sequences, with a
// scoreboard queue of expected output words compared as the DUT emits them.
`timescale 1ns/1ps
module tb_kpt_out_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        kpt_valid = 1'b0;
    logic        kpt_ready;
    logic [8:0]  kpt_row = '0;
    logic [9:0]  kpt_col = '0;
    logic        kpt_layer = 1'b0;
    logic        frame_end = 1'b0;
    logic        out_valid;
    logic [15:0] out_data;
    logic [15:0] kpt_count;

    always #5 clk = ~clk;

    kpt_out_serializer #(
        .FIFO_DEPTH (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .kpt_valid (kpt_valid),
        .kpt_ready (kpt_ready),
        .kpt_row   (kpt_row),
        .kpt_col   (kpt_col),
        .kpt_layer (kpt_layer),
        .frame_end (frame_end),
        .out_valid (out_valid),
        .out_data  (out_data),
        .kpt_count (kpt_count)
    );

    typedef struct {
        int          row;
        int          col;
        logic        layer;
        logic        store;
        logic [15:0] w0;
        logic [15:0] w1;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_count = '0;
    logic [15:0] mon_exp;
    int          run_len = 0;
    int          max_run = 0;
    bit          saw_stall = 1'b0;
    vec_t        tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired before the DUT responded", name);
    endtask

    function automatic logic [15:0] w0_of(input logic layer, input int col);
        logic [9:0] c;
        c = 10'(col);
        return {1'b0, layer, 4'b0000, c};
    endfunction

    function automatic logic [15:0] w1_of(input int row);
        logic [8:0] r;
        r = 9'(row);
        return {7'b0, r};
    endfunction

    // Output monitor: every emitted word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            run_len++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word: got %h, expected no output", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_word", 32'(out_data), 32'(mon_exp));
            end
        end else begin
            if (run_len > max_run) max_run = run_len;
            run_len = 0;
        end
    end

    task automatic push_eof();
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(model_count);
        model_count = '0;
    endtask

    // Called at posedge+1; offers one record until accepted, leaves at posedge+1.
    task automatic send(input int row, input int col, input logic layer, input logic fe,
                        input logic store, input logic [15:0] w0, input logic [15:0] w1);
        bit done;
        done      = 1'b0;
        kpt_valid = 1'b1;
        kpt_row   = 9'(row);
        kpt_col   = 10'(col);
        kpt_layer = layer;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (kpt_ready) begin
                done      = 1'b1;
                frame_end = fe;
                if (store) begin
                    exp_q.push_back(w0);
                    exp_q.push_back(w1);
                    if (model_count != 16'hFFFF) model_count = model_count + 16'd1;
                end
                if (fe) push_eof();
            end else begin
                saw_stall = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        kpt_valid = 1'b0;
        frame_end = 1'b0;
        if (!done) fail_now("send_accept");
    endtask

    task automatic pulse_fe();
        frame_end = 1'b1;
        push_eof();
        @(posedge clk);
        #1;
        frame_end = 1'b0;
    endtask

    task automatic idle(input int n);
        kpt_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int budget);
        for (int t = 0; t < budget && exp_q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            fail_now("drain");
            exp_q.delete();
        end
        idle(4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{row: 479, col: 639,  layer: 1'b1, store: 1'b1, w0: 16'h427F, w1: 16'h01DF};
        tbl[1] = '{row: 0,   col: 640,  layer: 1'b0, store: 1'b0, w0: 16'h0000, w1: 16'h0000};
        tbl[2] = '{row: 480, col: 0,    layer: 1'b1, store: 1'b0, w0: 16'h0000, w1: 16'h0000};
        tbl[3] = '{row: 0,   col: 0,    layer: 1'b0, store: 1'b1, w0: 16'h0000, w1: 16'h0000};
        tbl[4] = '{row: 100, col: 512,  layer: 1'b1, store: 1'b1, w0: 16'h4200, w1: 16'h0064};
        tbl[5] = '{row: 479, col: 1023, layer: 1'b0, store: 1'b0, w0: 16'h0000, w1: 16'h0000};
        tbl[6] = '{row: 511, col: 5,    layer: 1'b1, store: 1'b0, w0: 16'h0000, w1: 16'h0000};
        tbl[7] = '{row: 255, col: 300,  layer: 1'b0, store: 1'b1, w0: 16'h012C, w1: 16'h00FF};
        tbl[8] = '{row: 1,   col: 1,    layer: 1'b1, store: 1'b1, w0: 16'h4001, w1: 16'h0001};

        // Reset state
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'h0000);
        check("rst_kpt_count", 32'(kpt_count), 32'd0);
        check("rst_kpt_ready", 32'(kpt_ready), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 32'(kpt_ready), 32'd1);

        // Single keypoint with W0 latency
        send(5, 6, 1'b0, 1'b0, 1'b1, 16'h0006, 16'h0005);
        check("w0_not_yet", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("w0_valid_latency", 32'(out_valid), 32'd1);
        check("w0_data_latency",  32'(out_data),  32'h0006);
        idle(2);
        pulse_fe();
        drain(50);

        // Table of records, including out-of-range ones that must vanish
        for (int i = 0; i < 9; i++) begin
            send(tbl[i].row, tbl[i].col, tbl[i].layer, 1'b0, tbl[i].store, tbl[i].w0, tbl[i].w1);
            check($sformatf("tbl%0d_kpt_count", i), 32'(kpt_count), 32'(model_count));
            idle(1);
        end
        pulse_fe();
        drain(100);

        // Empty frame, then a back-to-back second frame_end that must be ignored
        pulse_fe();
        drain(50);
        frame_end = 1'b1;
        push_eof();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        frame_end = 1'b0;
        drain(50);

        // Burst of 20: no stall, gap-free 40 data words plus EOF and count
        max_run   = 0;
        saw_stall = 1'b0;
        for (int i = 0; i < 20; i++)
            send(i, i * 3, i[0], 1'b0, 1'b1, w0_of(i[0], i * 3), w1_of(i));
        pulse_fe();
        drain(200);
        check("burst20_no_stall", 32'(saw_stall), 32'd0);
        check("burst20_run_len", 32'(max_run), 32'd42);

        // Burst of 40: the FIFO fills and kpt_ready must drop
        max_run   = 0;
        saw_stall = 1'b0;
        for (int i = 0; i < 40; i++)
            send(400 - i, 600 - i * 7, ~i[1], 1'b0, 1'b1, w0_of(~i[1], 600 - i * 7), w1_of(400 - i));
        pulse_fe();
        drain(300);
        check("burst40_stall_seen", 32'(saw_stall), 32'd1);
        check("burst40_run_len", 32'(max_run), 32'd82);

        // frame_end with the 3rd record; 4th held until the count word is out
        send(10, 20, 1'b0, 1'b0, 1'b1, 16'h0014, 16'h000A);
        send(11, 21, 1'b1, 1'b0, 1'b1, 16'h4015, 16'h000B);
        send(12, 22, 1'b0, 1'b1, 1'b1, 16'h0016, 16'h000C);
        check("eof_pending_ready", 32'(kpt_ready), 32'd0);
        send(13, 23, 1'b1, 1'b0, 1'b1, 16'h4017, 16'h000D);
        check("next_frame_count", 32'(kpt_count), 32'd1);
        idle(1);
        pulse_fe();
        drain(100);

        // Reset while records are buffered
        for (int i = 0; i < 10; i++)
            send(50 + i, 60 + i, 1'b1, 1'b0, 1'b1, w0_of(1'b1, 60 + i), w1_of(50 + i));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_kpt_count", 32'(kpt_count), 32'd0);
        check("midrst_kpt_ready", 32'(kpt_ready), 32'd0);
        exp_q.delete();
        model_count = '0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(30);
        check("post_rst_count", 32'(kpt_count), 32'd0);
        check("post_rst_ready", 32'(kpt_ready), 32'd1);
        send(7, 8, 1'b1, 1'b1, 1'b1, 16'h4008, 16'h0007);
        check("post_rst_first_count", 32'(kpt_count), 32'd1);
        drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
